fwd_stall_unit: RTL

- Parametrised operand-forwarding and interlock unit between the ID stage, the register file and the NUM_STAGES downstream pipeline stages (ALU, MEM, WB, and any added later).
- Serves NUM_READ ID read ports with the youngest in-flight value for each register.
- Raises Stall when the matching producer has not yet computed its result (load-use or multi-cycle op).
- Keeps a one-entry retire buffer covering the cycle after WB, and counts stall cycles.

---
 rtl/fwd_stall_unit_if.sv | 32 +++
 rtl/fwd_stall_unit.sv | 117 +++++++++++
 2 files changed

// File: rtl/fwd_stall_unit_if.sv
// fwd_stall_unit_if: ID, register-file and pipeline-stage signal bundle for fwd_stall_unit
interface fwd_stall_unit_if #(
    parameter int WORD_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int NUM_READ       = 3,
    parameter int NUM_STAGES     = 3,
    parameter int CNT_WIDTH      = 16
);
    logic [NUM_READ-1:0]                ID_ReadEn;
    logic [NUM_READ*REG_ADDR_WIDTH-1:0] ID_ReadAddr;
    logic [NUM_READ*WORD_WIDTH-1:0]     ID_ReadData;
    logic [NUM_READ*REG_ADDR_WIDTH-1:0] RF_ReadAddr;
    logic [NUM_READ*WORD_WIDTH-1:0]     RF_ReadData;
    logic [NUM_STAGES-1:0]                ST_WbEnable;
    logic [NUM_STAGES*REG_ADDR_WIDTH-1:0] ST_WriteAddr;
    logic [NUM_STAGES-1:0]                ST_DataReady;
    logic [NUM_STAGES*WORD_WIDTH-1:0]     ST_Data;
    logic                 Stall;
    logic [NUM_READ-1:0]  FwdHit;
    logic [7:0]           StallCycles;
    logic [CNT_WIDTH-1:0] StallTotal;
    modport master (
        output ID_ReadEn, ID_ReadAddr, RF_ReadData,
        output ST_WbEnable, ST_WriteAddr, ST_DataReady, ST_Data,
        input  ID_ReadData, RF_ReadAddr, Stall, FwdHit, StallCycles, StallTotal
    );
    modport slave (
        input  ID_ReadEn, ID_ReadAddr, RF_ReadData,
        input  ST_WbEnable, ST_WriteAddr, ST_DataReady, ST_Data,
        output ID_ReadData, RF_ReadAddr, Stall, FwdHit, StallCycles, StallTotal
    );
endinterface

// File: rtl/fwd_stall_unit.sv
// fwd_stall_unit: operand forwarding, load-use interlock, retire buffer and stall counters; ZERO_REG_EN hardwires r0 to zero
module fwd_stall_unit #(
    parameter int WORD_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int NUM_READ       = 3,
    parameter int NUM_STAGES     = 3,
    parameter int CNT_WIDTH      = 16
) (
    input logic gclk,
    input logic grst_n,
    fwd_stall_unit_if.slave bus
);
    localparam int WW  = WORD_WIDTH;
    localparam int RAW = REG_ADDR_WIDTH;
`ifdef ZERO_REG_EN
    localparam logic ZERO_EN = 1'b1;
`else
    localparam logic ZERO_EN = 1'b0;
`endif

    typedef enum logic {RUN, STALLED} state_t;

    state_t                 r_state, w_state_nxt;
    logic                   r_hold_valid;
    logic [RAW-1:0]         r_hold_addr;
    logic [WW-1:0]          r_hold_data;
    logic [7:0]             r_stall_cycles, w_stall_cycles_nxt;
    logic [CNT_WIDTH-1:0]   r_stall_total;
    logic [NUM_STAGES-1:0]  w_st_live;
    logic [NUM_READ-1:0]    w_hit, w_blocked;
    logic [NUM_READ*WW-1:0] w_rd_data;
    logic                   w_stall, w_wb_load, w_total_inc;

    always_comb begin
        for (int k = 0; k < NUM_STAGES; k++)
            w_st_live[k] = bus.ST_WbEnable[k] && !(ZERO_EN && bus.ST_WriteAddr[k*RAW +: RAW] == '0);
    end

    assign w_wb_load = w_st_live[NUM_STAGES-1];

    // Youngest matching stage wins outright, ready or not; the retire buffer only fills in when no stage matches.
    always_comb begin
        logic [RAW-1:0] a;
        logic           found;
        a         = '0;
        found     = 1'b0;
        w_rd_data = bus.RF_ReadData;
        w_hit     = '0;
        w_blocked = '0;
        for (int i = 0; i < NUM_READ; i++) begin
            a     = bus.ID_ReadAddr[i*RAW +: RAW];
            found = 1'b0;
            if (r_hold_valid && r_hold_addr == a) begin
                w_rd_data[i*WW +: WW] = r_hold_data;
                w_hit[i]              = 1'b1;
            end
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (!found && w_st_live[k] && bus.ST_WriteAddr[k*RAW +: RAW] == a) begin
                    found                 = 1'b1;
                    w_rd_data[i*WW +: WW] = bus.ST_Data[k*WW +: WW];
                    w_hit[i]              = 1'b1;
                    w_blocked[i]          = !bus.ST_DataReady[k];
                end
            end
            if (ZERO_EN && a == '0) begin
                w_rd_data[i*WW +: WW] = '0;
                w_hit[i]              = 1'b0;
                w_blocked[i]          = 1'b0;
            end
        end
    end

    assign w_stall     = grst_n && |(bus.ID_ReadEn & w_blocked);
    assign w_total_inc = w_stall && !(&r_stall_total);

    assign bus.ID_ReadData = w_rd_data;
    assign bus.RF_ReadAddr = bus.ID_ReadAddr;
    assign bus.FwdHit      = w_hit;
    assign bus.Stall       = w_stall;
    assign bus.StallCycles = r_stall_cycles;
    assign bus.StallTotal  = r_stall_total;

    // The register file commits at the edge but still returns the old value next cycle, so WB is held one cycle.
    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_addr  <= '0;
            r_hold_data  <= '0;
        end else begin
            r_hold_valid <= w_wb_load;
            if (w_wb_load) begin
                r_hold_addr <= bus.ST_WriteAddr[(NUM_STAGES-1)*RAW +: RAW];
                r_hold_data <= bus.ST_Data[(NUM_STAGES-1)*WW +: WW];
            end
        end
    end

    always_ff @(posedge gclk) begin
        if (!grst_n) begin
            r_state        <= RUN;
            r_stall_cycles <= '0;
            r_stall_total  <= '0;
        end else begin
            r_state        <= w_state_nxt;
            r_stall_cycles <= w_stall_cycles_nxt;
            r_stall_total  <= r_stall_total + {{(CNT_WIDTH-1){1'b0}}, w_total_inc};
        end
    end

    always_comb begin
        w_state_nxt        = w_stall ? STALLED : RUN;
        w_stall_cycles_nxt = !w_stall             ? 8'd0 :
                             (r_state == RUN)     ? 8'd1 :
                             (&r_stall_cycles)    ? r_stall_cycles :
                                                    r_stall_cycles + 8'd1;
    end
endmodule
